// File: rtl/pos_cell_arbiter_if.sv
// -----------------------------------------------------------------------------
// pos_cell_arbiter_if
// Requester-side bus of the position cell arbiter: one read port (force
// evaluation) and one write-back port (motion update).
//   rd_req/rd_addr      : read request, held until rd_gnt
//   rd_gnt              : read accepted this cycle (combinational)
//   rd_valid/rd_data    : read return, three cycles after acceptance
//   wr_req/wr_addr/wr_data : write request, held until wr_gnt
//   wr_gnt              : write accepted this cycle (combinational)
// modport master : requester side
// modport slave  : arbiter side
// -----------------------------------------------------------------------------
interface pos_cell_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 96
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_valid, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_valid, rd_data, wr_gnt
  );
endinterface

// File: rtl/pos_cell_arbiter.sv
// -----------------------------------------------------------------------------
// pos_cell_arbiter
// Shares one single-port cell RAM (2-cycle read latency) between a read
// requester and a write-back requester. After reset it first reads word 0
// (the particle count of the cell) and caches it, then serves requests, one
// grant per cycle.
//
// Ports:
//   clk            : clock, all logic on the rising edge
//   rst_n          : asynchronous active-low reset
//   bus            : requester bus (pos_cell_arbiter_if.slave)
//   mem_address    : RAM address (registered)
//   mem_data       : RAM write data (registered)
//   mem_rden       : RAM read enable (registered)
//   mem_wren       : RAM write enable (registered)
//   mem_q          : RAM read data, valid two cycles after mem_rden
//   particle_count : cached low bits of word 0
//   count_valid    : particle_count has been loaded
//   addr_err       : sticky flag, a request addressed beyond PARTICLE_NUM
//
// Configuration macro:
//   POS_ARB_RR_EN  : defined   -> round-robin on conflicts, write first
//                    undefined -> write always wins a conflict
// -----------------------------------------------------------------------------
module pos_cell_arbiter #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pos_cell_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_valid,
  output logic                  addr_err
);

  // One extra bit so PARTICLE_NUM == 2**ADDR_WIDTH would still compare right.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

  typedef enum logic [1:0] {
    INIT_RD   = 2'd0,
    INIT_WAIT = 2'd1,
    SERVE     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            init_cnt_q, init_cnt_d;
  logic                  mem_rden_q, mem_rden_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ADDR_WIDTH-1:0] particle_count_q, particle_count_d;
  logic                  count_valid_q, count_valid_d;
  logic                  addr_err_q, addr_err_d;

  // Read-return pipeline: stage n is the read accepted n cycles ago.
  // The zero flag marks out-of-range reads that never reached the RAM.
  logic                  rd_p1_vld_q, rd_p1_vld_d;
  logic                  rd_p2_vld_q, rd_p2_vld_d;
  logic                  rd_p3_vld_q, rd_p3_vld_d;
  logic                  rd_p1_zero_q, rd_p1_zero_d;
  logic                  rd_p2_zero_q, rd_p2_zero_d;
  logic                  rd_p3_zero_q, rd_p3_zero_d;

`ifdef POS_ARB_RR_EN
  logic                  prefer_wr_q, prefer_wr_d;
`endif

  logic                  rd_gnt_s;
  logic                  wr_gnt_s;
  logic                  rd_oob_s;
  logic                  wr_oob_s;

  assign rd_oob_s = ({1'b0, bus.rd_addr} >= ADDR_LIMIT);
  assign wr_oob_s = ({1'b0, bus.wr_addr} >= ADDR_LIMIT);

  // Next-state, arbitration and RAM command decode.
  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    mem_rden_d       = 1'b0;
    mem_wren_d       = 1'b0;
    mem_address_d    = mem_address_q;
    mem_data_d       = mem_data_q;
    particle_count_d = particle_count_q;
    count_valid_d    = count_valid_q;
    addr_err_d       = addr_err_q;
    rd_p1_vld_d      = 1'b0;
    rd_p1_zero_d     = 1'b0;
    rd_p2_vld_d      = rd_p1_vld_q;
    rd_p2_zero_d     = rd_p1_zero_q;
    rd_p3_vld_d      = rd_p2_vld_q;
    rd_p3_zero_d     = rd_p2_zero_q;
    rd_gnt_s         = 1'b0;
    wr_gnt_s         = 1'b0;
`ifdef POS_ARB_RR_EN
    prefer_wr_d      = prefer_wr_q;
`endif

    case (state_q)
      INIT_RD: begin
        mem_rden_d    = 1'b1;
        mem_address_d = {ADDR_WIDTH{1'b0}};
        init_cnt_d    = 2'd0;
        state_d       = INIT_WAIT;
      end

      INIT_WAIT: begin
        // mem_rden is visible in the first INIT_WAIT cycle; the word
        // appears on mem_q two cycles later, in the third one.
        if (init_cnt_q == 2'd2) begin
          particle_count_d = mem_q[ADDR_WIDTH-1:0];
          count_valid_d    = 1'b1;
          state_d          = SERVE;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end

      SERVE: begin
`ifdef POS_ARB_RR_EN
        if (bus.rd_req && bus.wr_req) begin
          if (prefer_wr_q) begin
            wr_gnt_s = 1'b1;
          end else begin
            rd_gnt_s = 1'b1;
          end
          prefer_wr_d = ~prefer_wr_q;
        end else begin
          wr_gnt_s = bus.wr_req;
          rd_gnt_s = bus.rd_req;
        end
`else
        wr_gnt_s = bus.wr_req;
        rd_gnt_s = bus.rd_req & ~bus.wr_req;
`endif

        if (wr_gnt_s) begin
          if (wr_oob_s) begin
            addr_err_d = 1'b1;
          end else begin
            mem_wren_d    = 1'b1;
            mem_address_d = bus.wr_addr;
            mem_data_d    = bus.wr_data;
            if (bus.wr_addr == {ADDR_WIDTH{1'b0}}) begin
              particle_count_d = bus.wr_data[ADDR_WIDTH-1:0];
            end else begin
              particle_count_d = particle_count_q;
            end
          end
        end else if (rd_gnt_s) begin
          rd_p1_vld_d = 1'b1;
          if (rd_oob_s) begin
            addr_err_d   = 1'b1;
            rd_p1_zero_d = 1'b1;
          end else begin
            mem_rden_d    = 1'b1;
            mem_address_d = bus.rd_addr;
          end
        end else begin
          mem_rden_d = 1'b0;
          mem_wren_d = 1'b0;
        end
      end

      default: begin
        state_d = INIT_RD;
      end
    endcase
  end

  // State and output registers; reset drops reads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= INIT_RD;
      init_cnt_q       <= 2'd0;
      mem_rden_q       <= 1'b0;
      mem_wren_q       <= 1'b0;
      mem_address_q    <= {ADDR_WIDTH{1'b0}};
      mem_data_q       <= {DATA_WIDTH{1'b0}};
      particle_count_q <= {ADDR_WIDTH{1'b0}};
      count_valid_q    <= 1'b0;
      addr_err_q       <= 1'b0;
      rd_p1_vld_q      <= 1'b0;
      rd_p2_vld_q      <= 1'b0;
      rd_p3_vld_q      <= 1'b0;
      rd_p1_zero_q     <= 1'b0;
      rd_p2_zero_q     <= 1'b0;
      rd_p3_zero_q     <= 1'b0;
`ifdef POS_ARB_RR_EN
      prefer_wr_q      <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      init_cnt_q       <= init_cnt_d;
      mem_rden_q       <= mem_rden_d;
      mem_wren_q       <= mem_wren_d;
      mem_address_q    <= mem_address_d;
      mem_data_q       <= mem_data_d;
      particle_count_q <= particle_count_d;
      count_valid_q    <= count_valid_d;
      addr_err_q       <= addr_err_d;
      rd_p1_vld_q      <= rd_p1_vld_d;
      rd_p2_vld_q      <= rd_p2_vld_d;
      rd_p3_vld_q      <= rd_p3_vld_d;
      rd_p1_zero_q     <= rd_p1_zero_d;
      rd_p2_zero_q     <= rd_p2_zero_d;
      rd_p3_zero_q     <= rd_p3_zero_d;
`ifdef POS_ARB_RR_EN
      prefer_wr_q      <= prefer_wr_d;
`endif
    end
  end

  assign bus.rd_gnt   = rd_gnt_s;
  assign bus.wr_gnt   = wr_gnt_s;
  assign bus.rd_valid = rd_p3_vld_q;
  // mem_q is only meaningful in the return cycle of a real RAM read; a
  // write followed by a read of the same word needs no bypass because the
  // single RAM port serialises them.
  assign bus.rd_data  = (rd_p3_vld_q && !rd_p3_zero_q) ? mem_q : {DATA_WIDTH{1'b0}};

  assign mem_rden       = mem_rden_q;
  assign mem_wren       = mem_wren_q;
  assign mem_address    = mem_address_q;
  assign mem_data       = mem_data_q;
  assign particle_count = particle_count_q;
  assign count_valid    = count_valid_q;
  assign addr_err       = addr_err_q;

endmodule
